ram_master: RTL and testbench
=============================

RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameter: N, 68, highest valid RAM location index (locations 0..N).
REQ-002 Parameter: M, 8, data width.
REQ-003 Parameter: A, 7, address width.
REQ-004 Parameter: WAIT_CYC, 1, number of ACCESS cycles per transfer (legal range 1..15).
REQ-005 Port clk1  in  1  sole clock, rising edge.
REQ-006 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port req  in  1  transfer request, sampled in IDLE.
REQ-008 Port we_req  in  1  1 = write, 0 = read; sampled with req.
REQ-009 Port addr_in  in  A  transfer address; sampled with req.
REQ-010 Port wdata_in  in  M  write data; sampled with req.
REQ-011 Port busy  out  1  high in every non-IDLE state.
REQ-012 Port done  out  1  one-cycle completion pulse.
REQ-013 Port err  out  1  one-cycle range-error pulse, coincident with done.
REQ-014 Port rdata_out  out  M  last read data, held until the next read completes.
REQ-015 Port address_r  out  A  RAM address.
REQ-016 Port writeEn  out  1  RAM write enable.
REQ-017 Port act_ram  out  1  RAM select.
REQ-018 Port data  inout  M  shared tristate RAM data bus.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, ACCESS, HOLD and DONE, and all outputs SHALL be registered or decoded from the state register only.
REQ-020 In IDLE with req=1, the block SHALL latch we_req, addr_in and wdata_in and go to SETUP; req=0 SHALL keep it in IDLE.
REQ-021 req SHALL be ignored while busy=1, with no queuing.
REQ-022 SETUP SHALL last 1 cycle, with address_r valid and act_ram=0, writeEn=0; on a write, data SHALL be driven with the latched wdata.
REQ-023 ACCESS SHALL last exactly WAIT_CYC cycles, counted by an internal down-counter: act_ram=1, and writeEn=1 for writes or writeEn=0 for reads.
REQ-024 On a read, the ram_master SHALL keep data at high impedance throughout, and rdata_out SHALL capture data on the clock edge that leaves ACCESS.
REQ-025 HOLD SHALL last 1 cycle with act_ram=0 and writeEn=0, and address_r and write data SHALL remain stable for write hold time.
REQ-026 DONE SHALL last 1 cycle with done=1 and data released, then return to IDLE.
REQ-027 done SHALL rise exactly WAIT_CYC+2 clock edges after the acceptance edge, so a new req can be accepted in the DONE+1 cycle.
REQ-028 data SHALL be driven only during write SETUP/ACCESS/HOLD and SHALL be 'z' in all other states, so there is never contention with RAM read drive.
REQ-029 writeEn SHALL never be 1 while act_ram=0.
REQ-030 address_r SHALL hold its last value in IDLE.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, independent of clk1, go to IDLE and set busy=0, done=0, err=0, act_ram=0, writeEn=0, address_r=0, rdata_out=0, wait counter=0, and data='z'.
REQ-032 A reset during any transfer SHALL abort it without a done pulse, and the aborted write SHALL be treated as undefined at the RAM.
REQ-033 After rst_n rises, the first req SHALL be accepted on the next rising edge.

Configuration
REQ-034 With RAM_MASTER_RANGE_CHK_EN defined, a request with addr_in > N SHALL go IDLE -> DONE directly with err=1 and done=1, with no bus activity (act_ram, writeEn stay 0; data 'z') and rdata_out unchanged.
REQ-035 Without RAM_MASTER_RANGE_CHK_EN, err SHALL be tied to 0 and every address SHALL be issued to the bus unchecked.

Verification
REQ-036 Write 0xA5 to address 0x10 (WAIT_CYC=1), then read 0x10 -> read sets rdata_out=0xA5 and done rises 3 edges after each acceptance.
REQ-037 With WAIT_CYC=3 on a write, act_ram=1 for exactly 3 cycles, writeEn=1 only inside those cycles, and data is driven from SETUP through HOLD.
REQ-038 Issue req every cycle during a read to address 0x05 -> only one transfer occurs, busy=1 throughout, and the next request is accepted the cycle after DONE.
REQ-039 Deassert rst_n in the second ACCESS cycle of a write (WAIT_CYC=3) -> act_ram=0, writeEn=0 and data='z' within the same cycle, with no done pulse.
REQ-040 With RAM_MASTER_RANGE_CHK_EN defined, request a read of address 69 -> done=1 and err=1 on the next edge, act_ram never asserts, and rdata_out is unchanged; without the macro, act_ram asserts for address 69.

Source files
------------

// File: rtl/ram_master.sv
// Single-port RAM bus master: IDLE/SETUP/ACCESS/HOLD/DONE cycle on a tristate data bus.
// Optional address range check enabled by defining RAM_MASTER_RANGE_CHK_EN.
module ram_master #(
  parameter int N        = 68,
  parameter int M        = 8,
  parameter int A        = 7,
  parameter int WAIT_CYC = 1
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         req,
  input  logic         we_req,
  input  logic [A-1:0] addr_in,
  input  logic [M-1:0] wdata_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [M-1:0] rdata_out,
  output logic [A-1:0] address_r,
  output logic         writeEn,
  output logic         act_ram,
  inout  wire  [M-1:0] data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  if (WAIT_CYC < 1 || WAIT_CYC > 15 || N < 0 || N >= (1 << A))
  begin : g_bad_param
    $error("ram_master: illegal WAIT_CYC or N");
  end

  state_t       state;
  state_t       state_nx;
  logic [3:0]   cnt;
  logic         we_r;
  logic [M-1:0] wdata_r;
  logic         oob;
  logic         drive;
  logic         last;

`ifdef RAM_MASTER_RANGE_CHK_EN
  localparam logic [A-1:0] ADDR_MAX = A'(N);
  logic err_r;

  assign oob = addr_in > ADDR_MAX;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (state == IDLE) begin
      err_r <= req & oob;
    end
  end

  assign err = done & err_r;
`else
  assign oob = 1'b0;
  assign err = 1'b0;
`endif

  assign last = (cnt == 4'd0);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req) state_nx = oob ? DONE : SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (last) state_nx = HOLD;
      HOLD:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state register and latched request.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    act_ram = (state == ACCESS);
    writeEn = (state == ACCESS) & we_r;
    drive   = we_r & ((state == SETUP) |
                      (state == ACCESS) |
                      (state == HOLD));
  end

  assign data = drive ? wdata_r : {M{1'bz}};

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      we_r      <= 1'b0;
      wdata_r   <= '0;
      address_r <= '0;
      cnt       <= 4'd0;
      rdata_out <= '0;
    end else begin
      if (state == IDLE && req && !oob) begin
        we_r      <= we_req;
        wdata_r   <= wdata_in;
        address_r <= addr_in;
      end
      if (state == SETUP) begin
        cnt <= CNT_INIT;
      end else if (state == ACCESS && !last) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACCESS && last && !we_r) begin
        rdata_out <= data;
      end
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: one instance with WAIT_CYC=1, one with WAIT_CYC=3.
// Each instance sits on its own bus with a small behavioural RAM.
module tb_ram_master;

  logic clk1 = 1'b0;
  logic rst_n;

  always #5 clk1 = ~clk1;

  logic       req1, we1;
  logic [6:0] addr1;
  logic [7:0] wd1;
  logic       busy1, done1, err1, wen1, act1;
  logic [7:0] rd1;
  logic [6:0] ar1;
  wire  [7:0] data1;
  logic [7:0] mem1 [128] = '{default: 8'h00};

  logic       req3, we3;
  logic [6:0] addr3;
  logic [7:0] wd3;
  logic       busy3, done3, err3, wen3, act3;
  logic [7:0] rd3;
  logic [6:0] ar3;
  wire  [7:0] data3;
  logic [7:0] mem3 [128] = '{default: 8'h00};

  ram_master #(.N(68), .M(8), .A(7), .WAIT_CYC(1)) u_dut1 (
    .clk1(clk1), .rst_n(rst_n), .req(req1), .we_req(we1),
    .addr_in(addr1), .wdata_in(wd1), .busy(busy1), .done(done1),
    .err(err1), .rdata_out(rd1), .address_r(ar1), .writeEn(wen1),
    .act_ram(act1), .data(data1)
  );

  ram_master #(.N(68), .M(8), .A(7), .WAIT_CYC(3)) u_dut3 (
    .clk1(clk1), .rst_n(rst_n), .req(req3), .we_req(we3),
    .addr_in(addr3), .wdata_in(wd3), .busy(busy3), .done(done3),
    .err(err3), .rdata_out(rd3), .address_r(ar3), .writeEn(wen3),
    .act_ram(act3), .data(data3)
  );

  assign data1 = (act1 && !wen1) ? mem1[ar1] : 8'hzz;
  assign data3 = (act3 && !wen3) ? mem3[ar3] : 8'hzz;

  always @(posedge clk1) if (act1 && wen1) mem1[ar1] <= data1;
  always @(posedge clk1) if (act3 && wen3) mem3[ar3] <= data3;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic xfer1(input logic w, input logic [6:0] a,
                       input logic [7:0] d);
    int n;
    req1 = 1'b1; we1 = w; addr1 = a; wd1 = d;
    tick;
    req1 = 1'b0;
    n = 0;
    while (!done1 && n < 10) begin
      tick;
      n++;
    end
    chk("xfer1_done", done1, 1);
    tick;
  endtask

  initial begin
    int act_n, wen_n, drv_n, bad_n, done_at, n;
    logic seen, eseen;

    rst_n = 1'b0;
    req1 = 0; we1 = 0; addr1 = 0; wd1 = 0;
    req3 = 0; we3 = 0; addr3 = 0; wd3 = 0;
    #12;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_err", err1, 0);
    chk("rst_act", act1, 0);
    chk("rst_wen", wen1, 0);
    chk("rst_addr", ar1, 0);
    chk("rst_rdata", rd1, 0);
    chk("rst_dataz", data1 === 8'hzz, 1);
    @(posedge clk1);
    #1;
    rst_n = 1'b1;

    // write 0xA5 to 0x10, WAIT_CYC=1
    req1 = 1; we1 = 1; addr1 = 7'h10; wd1 = 8'hA5;
    tick;
    req1 = 0;
    chk("wr_setup_busy", busy1, 1);
    chk("wr_setup_act", act1, 0);
    chk("wr_setup_wen", wen1, 0);
    chk("wr_setup_addr", ar1, 7'h10);
    chk("wr_setup_data", data1, 8'hA5);
    tick;
    chk("wr_acc_act", act1, 1);
    chk("wr_acc_wen", wen1, 1);
    chk("wr_acc_done", done1, 0);
    tick;
    chk("wr_hold_act", act1, 0);
    chk("wr_hold_wen", wen1, 0);
    chk("wr_hold_data", data1, 8'hA5);
    chk("wr_hold_addr", ar1, 7'h10);
    tick;
    chk("wr_done", done1, 1);
    chk("wr_err", err1, 0);
    chk("wr_done_dataz", data1 === 8'hzz, 1);
    tick;
    chk("wr_idle_busy", busy1, 0);
    chk("wr_idle_done", done1, 0);
    chk("idle_addr_hold", ar1, 7'h10);
    chk("ram_a5", mem1[16], 8'hA5);

    // read back 0x10
    req1 = 1; we1 = 0; addr1 = 7'h10;
    tick;
    req1 = 0;
    chk("rd_setup_dataz", data1 === 8'hzz, 1);
    tick;
    chk("rd_acc_act", act1, 1);
    chk("rd_acc_wen", wen1, 0);
    tick;
    chk("rd_rdata", rd1, 8'hA5);
    tick;
    chk("rd_done", done1, 1);
    tick;

    // req held high during a read of 0x05
    xfer1(1'b1, 7'h05, 8'h3C);
    chk("wr_rdata_kept", rd1, 8'hA5);
    req1 = 1; we1 = 0; addr1 = 7'h05;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("hold_req_busy", busy1, 1);
      chk("hold_req_done", done1, (k == 3));
      if (k < 3) tick;
    end
    tick;
    chk("hold_req_idle", busy1, 0);
    chk("hold_req_rdata", rd1, 8'h3C);
    tick;
    chk("hold_req_reaccept", busy1, 1);
    req1 = 0;
    n = 0;
    while (!done1 && n < 10) begin
      tick;
      n++;
    end
    chk("reaccept_done", done1, 1);
    tick;

`ifdef RAM_MASTER_RANGE_CHK_EN
    req1 = 1; we1 = 0; addr1 = 7'd69;
    tick;
    req1 = 0;
    chk("oob_done", done1, 1);
    chk("oob_err", err1, 1);
    chk("oob_act", act1, 0);
    chk("oob_dataz", data1 === 8'hzz, 1);
    tick;
    chk("oob_idle", busy1, 0);
    chk("oob_err_clr", err1, 0);
    chk("oob_rdata", rd1, 8'h3C);
`else
    xfer1(1'b1, 7'd69, 8'h99);
    req1 = 1; we1 = 0; addr1 = 7'd69;
    tick;
    req1 = 0;
    seen = 0; eseen = 0;
    for (int i = 0; i < 8; i++) begin
      if (act1) seen = 1;
      if (err1) eseen = 1;
      if (done1) break;
      tick;
    end
    chk("noclk_act", seen, 1);
    chk("noclk_err", eseen, 0);
    chk("noclk_done", done1, 1);
    tick;
    chk("noclk_rdata", rd1, 8'h99);
`endif

    // write 0x5A to 0x22, WAIT_CYC=3
    req3 = 1; we3 = 1; addr3 = 7'h22; wd3 = 8'h5A;
    tick;
    req3 = 0;
    act_n = 0; wen_n = 0; drv_n = 0; bad_n = 0; done_at = -1;
    for (int i = 0; i < 7; i++) begin
      if (act3) act_n++;
      if (wen3) wen_n++;
      if (data3 === 8'h5A) drv_n++;
      if (wen3 && !act3) bad_n++;
      if (done3 && done_at < 0) done_at = i;
      tick;
    end
    chk("w3_act_cycles", act_n, 3);
    chk("w3_wen_cycles", wen_n, 3);
    chk("w3_drive_cycles", drv_n, 5);
    chk("w3_wen_no_act", bad_n, 0);
    chk("w3_done_at", done_at, 5);
    chk("w3_ram", mem3[34], 8'h5A);

    // reset in second ACCESS cycle of a write
    req3 = 1; we3 = 1; addr3 = 7'h30; wd3 = 8'h77;
    tick;
    req3 = 0;
    tick;
    tick;
    chk("abort_pre_act", act3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_act", act3, 0);
    chk("abort_wen", wen3, 0);
    chk("abort_dataz", data3 === 8'hzz, 1);
    chk("abort_busy", busy3, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done3) seen = 1;
      tick;
    end
    chk("abort_no_done", seen, 0);
    rst_n = 1'b1;
    req3 = 1; we3 = 0; addr3 = 7'h22;
    tick;
    req3 = 0;
    chk("post_rst_accept", busy3, 1);
    n = 0;
    while (!done3 && n < 12) begin
      tick;
      n++;
    end
    chk("post_rst_done", done3, 1);
    chk("post_rst_rdata", rd3, 8'h5A);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
